// File: rtl/fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_unit
//
// Instruction fetch stage for the 5-stage CPU. Generates sequential PCs, drives
// a synchronous instruction ROM with one cycle of read latency, and buffers the
// returned words in a DEPTH-entry prefetch queue that feeds decode over a
// valid/ready handshake. Supports branch redirect with flush, fetch halt, and
// prioritised interrupt injection with a busy lock held until the handler
// reports completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_en          allow new ROM requests (low = halt issue, queue drains)
//   redirect_valid    branch/jump redirect, highest priority
//   redirect_pc       redirect target
//   imem_en           ROM read strobe
//   imem_addr         ROM word address (PC[ADDR_W+1:2])
//   imem_rdata        ROM data, valid the cycle after imem_en
//   inst_valid        instruction offered to decode
//   inst_ready        decode accepts
//   inst, inst_pc     instruction word and its PC
//   inst_irq          one-hot interrupt source while an injection is offered
//   irq               level interrupt requests
//   irq_done          handler-complete pulse, clears the busy lock
//   irq_busy          interrupt injected and not yet completed
// -----------------------------------------------------------------------------
module fetch_prefetch_unit #(
  parameter int               N        = 32,
  parameter int               DEPTH    = 4,
  parameter int               ADDR_W   = 9,
  parameter logic [N-1:0]     RESET_PC = 32'h0,
  parameter int               NUM_IRQ  = 2,
  parameter logic [N-1:0]     IRQ_INST = 32'hA7C00000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [N-1:0]       redirect_pc,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [N-1:0]       imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [N-1:0]       inst,
  output logic [N-1:0]       inst_pc,
  output logic [NUM_IRQ-1:0] inst_irq,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_done,
  output logic               irq_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  // Fetch state
  logic [N-1:0]       pc;
  logic [N-1:0]       pc_q;
  logic               inflight;

  // Prefetch queue storage and bookkeeping
  logic [N-1:0]       q_inst [DEPTH];
  logic [N-1:0]       q_pc   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  // Combinational control
  logic               q_empty;
  logic               inject;
  logic               inject_hs;
  logic               pop;
  logic               push;
  logic               issue;
  logic [SUM_W-1:0]   credit_used;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [N-1:0]       return_pc;

  // Pick the highest-numbered active interrupt line. Later iterations
  // overwrite earlier ones, so the top set bit wins.
  always_comb begin
    irq_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq[i]) begin
        irq_onehot    = '0;
        irq_onehot[i] = 1'b1;
      end
    end
  end

  // Handshake, credit and output selection. rst_n gates issue and injection
  // so that every output is quiet while reset is held, whatever the inputs do.
  // An injection never pops the queue: the queued stream stays put and the
  // injected word borrows the head's PC as its return address.
  always_comb begin
    q_empty     = (count == '0);
    inject      = rst_n & (|irq) & ~irq_busy & ~redirect_valid;
    inst_valid  = (~q_empty | inject) & ~redirect_valid;
    pop         = inst_valid & inst_ready & ~inject;
    inject_hs   = inject & inst_ready;
    // Slots already spoken for after this cycle: entries held plus the word
    // in flight, minus the one leaving now. Issue only while a slot is free.
    credit_used = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop);
    issue       = rst_n & fetch_en & ~redirect_valid & (credit_used < SUM_W'(DEPTH));
    push        = inflight & ~redirect_valid;

    imem_en     = issue;
    imem_addr   = pc[ADDR_W+1:2];

    if (!q_empty)      return_pc = q_pc[rd_ptr];
    else if (inflight) return_pc = pc_q;
    else               return_pc = pc;

    if (inject) begin
      inst     = IRQ_INST;
      inst_pc  = return_pc;
      inst_irq = irq_onehot;
    end else if (!q_empty) begin
      inst     = q_inst[rd_ptr];
      inst_pc  = q_pc[rd_ptr];
      inst_irq = '0;
    end else begin
      inst     = '0;
      inst_pc  = '0;
      inst_irq = '0;
    end
  end

  // PC generation and the single outstanding ROM request. The PC of each
  // request is captured so the returning word can be tagged with it. A
  // redirect never coincides with an issue, so it simply overrides the PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      pc_q     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q <= pc;
        pc   <= pc + N'(4);
      end
      if (redirect_valid) begin
        pc <= redirect_pc;
      end
    end
  end

  // Queue pointers and occupancy. A redirect flushes everything, and the
  // word returning that cycle is dropped because push is masked by redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && count == CNT_W'(DEPTH)));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Queue storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= pc_q;
    end
  end

  // Busy lock: set when decode takes an injected interrupt, cleared by the
  // handler's done pulse. A new handshake in the same cycle as done wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_busy <= 1'b0;
    end else if (inject_hs) begin
      irq_busy <= 1'b1;
    end else if (irq_done) begin
      irq_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_unit
//
// Bench for fetch_prefetch_unit with default parameters. A behavioural ROM
// answers one cycle after imem_en. Each scenario pushes the PCs it expects
// decode to receive into a scoreboard queue; a negedge monitor pops and
// compares every non-interrupt transfer. Inputs change 1 ns after posedge,
// outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

  localparam logic [31:0] IRQ_WORD = 32'hA7C00000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [1:0]  inst_irq;
  logic [1:0]  irq;
  logic        irq_done;
  logic        irq_busy;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q [$];
  logic [31:0] sb_pc;

  fetch_prefetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_irq       (inst_irq),
    .irq            (irq),
    .irq_done       (irq_done),
    .irq_busy       (irq_busy)
  );

  always #5 clk = ~clk;

  // Distinct, address-derived ROM contents
  function automatic logic [31:0] rom_word(input logic [8:0] a);
    return {7'h2B, a, 7'h00, a};
  endfunction

  // Synchronous ROM with one cycle of latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom_word(imem_addr);
  end

  // Scoreboard monitor: every normal transfer must match the next expected PC
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1 && inst_irq === 2'b00) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL sb_unexpected: got pc=%h inst=%h, expected no transfer", inst_pc, inst);
      end else begin
        sb_pc = exp_q.pop_front();
        if (inst_pc !== sb_pc || inst !== rom_word(sb_pc[10:2])) begin
          tests_failed++;
          $display("[TB] FAIL sb_transfer: got pc=%h inst=%h, expected pc=%h inst=%h",
                   inst_pc, inst, sb_pc, rom_word(sb_pc[10:2]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic fe, input logic rdy);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    irq            = '0;
    irq_done       = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    fetch_en   = fe;
    inst_ready = rdy;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && inst_valid === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; fetch_en = 1'b1; inst_ready = 1'b1; irq = '0;
    redirect_valid = 1'b0; redirect_pc = '0; irq_done = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run += 7;
    if (imem_en !== 1'b0)     begin tests_failed++; $display("[TB] FAIL rst_imem_en: got %b, expected 0", imem_en); end
    if (imem_addr !== 9'h0)   begin tests_failed++; $display("[TB] FAIL rst_imem_addr: got %h, expected 0", imem_addr); end
    if (inst_valid !== 1'b0)  begin tests_failed++; $display("[TB] FAIL rst_inst_valid: got %b, expected 0", inst_valid); end
    if (inst !== 32'h0)       begin tests_failed++; $display("[TB] FAIL rst_inst: got %h, expected 0", inst); end
    if (inst_pc !== 32'h0)    begin tests_failed++; $display("[TB] FAIL rst_inst_pc: got %h, expected 0", inst_pc); end
    if (inst_irq !== 2'b00)   begin tests_failed++; $display("[TB] FAIL rst_inst_irq: got %b, expected 00", inst_irq); end
    if (irq_busy !== 1'b0)    begin tests_failed++; $display("[TB] FAIL rst_irq_busy: got %b, expected 0", irq_busy); end
  endtask

  task automatic test_sequential;
    bit ok;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests_run += 3;
      if (imem_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL seq_imem_en c%0d: got %b, expected 1", k, imem_en); end
      if (imem_addr !== 9'(k)) begin tests_failed++; $display("[TB] FAIL seq_imem_addr c%0d: got %h, expected %h", k, imem_addr, 9'(k)); end
      if (inst_valid !== (k >= 2)) begin tests_failed++; $display("[TB] FAIL seq_inst_valid c%0d: got %b, expected %b", k, inst_valid, (k >= 2)); end
      tick;
    end
    fetch_en = 1'b0;
    @(negedge clk);
    tests_run++;
    if (imem_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL seq_halt_en: got %b, expected 0", imem_en); end
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL seq_drain: %0d entries left, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure;
    bit ok;
    int issues;
    int n_valid;
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    issues = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (imem_en === 1'b1) issues++;
      tick;
    end
    tests_run++;
    if (issues != 4) begin tests_failed++; $display("[TB] FAIL bp_fill_issues: got %0d, expected 4", issues); end
    inst_ready = 1'b1;
    for (int i = 4; i < 7; i++) exp_q.push_back(32'(i * 4));
    issues  = 0;
    n_valid = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) n_valid++;
      if (imem_en === 1'b1) issues++;
      tick;
      if (k == 2) fetch_en = 1'b0;
    end
    tests_run += 2;
    if (issues != 3)  begin tests_failed++; $display("[TB] FAIL bp_restart_issues: got %0d, expected 3", issues); end
    if (n_valid != 7) begin tests_failed++; $display("[TB] FAIL bp_valid_run: got %0d, expected 7", n_valid); end
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL bp_drain: %0d entries left, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_full;
    bit ok;
    do_reset(1'b1, 1'b0);
    repeat (4) tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    tests_run += 2;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rf_valid_low: got %b, expected 0", inst_valid); end
    if (imem_en !== 1'b0)    begin tests_failed++; $display("[TB] FAIL rf_no_issue: got %b, expected 0", imem_en); end
    tick;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    @(negedge clk);
    tests_run += 3;
    if (imem_en !== 1'b1)      begin tests_failed++; $display("[TB] FAIL rf_resume_en: got %b, expected 1", imem_en); end
    if (imem_addr !== 9'h040)  begin tests_failed++; $display("[TB] FAIL rf_resume_addr: got %h, expected 040", imem_addr); end
    if (inst_valid !== 1'b0)   begin tests_failed++; $display("[TB] FAIL rf_squash: got %b, expected 0", inst_valid); end
    tick;
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rf_latency: got %b, expected 0", inst_valid); end
    tick;
    tick;
    fetch_en = 1'b0;
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL rf_drain: %0d entries left, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_ready;
    bit ok;
    do_reset(1'b1, 1'b1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (4) tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_no_transfer: got %b, expected 0", inst_valid); end
    tick;
    redirect_valid = 1'b0;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204); exp_q.push_back(32'h208);
    @(negedge clk);
    tests_run++;
    if (inst_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_flush: got %b, expected 0", inst_valid); end
    tick;
    tick;
    tick;
    fetch_en = 1'b0;
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL rr_drain: %0d entries left, expected 0", exp_q.size()); end
  endtask

  task automatic test_interrupt;
    bit ok;
    do_reset(1'b1, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick;
    redirect_valid = 1'b0;
    repeat (8) tick;
    irq = 2'b11;
    @(negedge clk);
    tests_run += 5;
    if (inst_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_valid: got %b, expected 1", inst_valid); end
    if (inst !== IRQ_WORD)   begin tests_failed++; $display("[TB] FAIL irq_inst: got %h, expected %h", inst, IRQ_WORD); end
    if (inst_irq !== 2'b10)  begin tests_failed++; $display("[TB] FAIL irq_onehot: got %b, expected 10", inst_irq); end
    if (inst_pc !== 32'h20)  begin tests_failed++; $display("[TB] FAIL irq_ret_pc: got %h, expected 00000020", inst_pc); end
    if (irq_busy !== 1'b0)   begin tests_failed++; $display("[TB] FAIL irq_busy_pre: got %b, expected 0", irq_busy); end
    tick;
    inst_ready = 1'b1;
    fetch_en   = 1'b0;
    @(negedge clk);
    tests_run++;
    if (inst_irq !== 2'b10) begin tests_failed++; $display("[TB] FAIL irq_offer: got %b, expected 10", inst_irq); end
    tick;
    inst_ready = 1'b0;
    @(negedge clk);
    tests_run += 4;
    if (irq_busy !== 1'b1)  begin tests_failed++; $display("[TB] FAIL irq_busy_set: got %b, expected 1", irq_busy); end
    if (inst_irq !== 2'b00) begin tests_failed++; $display("[TB] FAIL irq_locked: got %b, expected 00", inst_irq); end
    if (inst_pc !== 32'h20) begin tests_failed++; $display("[TB] FAIL irq_head_kept: got %h, expected 00000020", inst_pc); end
    if (inst !== rom_word(9'h008)) begin tests_failed++; $display("[TB] FAIL irq_head_inst: got %h, expected %h", inst, rom_word(9'h008)); end
    for (int k = 0; k < 3; k++) begin
      tick;
      @(negedge clk);
      tests_run++;
      if (inst_irq !== 2'b00) begin tests_failed++; $display("[TB] FAIL irq_no_reinject c%0d: got %b, expected 00", k, inst_irq); end
    end
    tick;
    irq_done = 1'b1;
    @(negedge clk);
    tests_run++;
    if (irq_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_busy_hold: got %b, expected 1", irq_busy); end
    tick;
    irq_done = 1'b0;
    irq      = 2'b01;
    @(negedge clk);
    tests_run += 3;
    if (irq_busy !== 1'b0)  begin tests_failed++; $display("[TB] FAIL irq_busy_clr: got %b, expected 0", irq_busy); end
    if (inst_irq !== 2'b01) begin tests_failed++; $display("[TB] FAIL irq_reinject: got %b, expected 01", inst_irq); end
    if (inst_pc !== 32'h20) begin tests_failed++; $display("[TB] FAIL irq_reinject_pc: got %h, expected 00000020", inst_pc); end
    tick;
    inst_ready = 1'b1;
    irq_done   = 1'b1;
    tick;
    inst_ready = 1'b0;
    irq_done   = 1'b0;
    @(negedge clk);
    tests_run++;
    if (irq_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_set_wins: got %b, expected 1", irq_busy); end
    tick;
    irq        = 2'b00;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h20 + 32'(i * 4));
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL irq_drain: %0d entries left, expected 0", exp_q.size()); end
    tick;
    irq_done = 1'b1;
    tick;
    irq_done = 1'b0;
    irq      = 2'b10;
    @(negedge clk);
    tests_run += 3;
    if (inst_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL irq_empty_valid: got %b, expected 1", inst_valid); end
    if (inst_irq !== 2'b10)  begin tests_failed++; $display("[TB] FAIL irq_empty_src: got %b, expected 10", inst_irq); end
    if (inst_pc !== 32'h30)  begin tests_failed++; $display("[TB] FAIL irq_empty_pc: got %h, expected 00000030", inst_pc); end
    tick;
    irq = 2'b00;
  endtask

  task automatic test_halt_wrap;
    bit ok;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    repeat (5) tick;
    fetch_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run += 2;
      if (imem_en !== 1'b0)     begin tests_failed++; $display("[TB] FAIL halt_en c%0d: got %b, expected 0", k, imem_en); end
      if (imem_addr !== 9'h005) begin tests_failed++; $display("[TB] FAIL halt_pc_hold c%0d: got %h, expected 005", k, imem_addr); end
      tick;
    end
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL halt_drain: %0d entries left, expected 0", exp_q.size()); end
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    @(negedge clk);
    tests_run += 2;
    if (imem_en !== 1'b1)     begin tests_failed++; $display("[TB] FAIL wrap_en0: got %b, expected 1", imem_en); end
    if (imem_addr !== 9'h1FF) begin tests_failed++; $display("[TB] FAIL wrap_addr0: got %h, expected 1ff", imem_addr); end
    tick;
    @(negedge clk);
    tests_run += 2;
    if (imem_en !== 1'b1)     begin tests_failed++; $display("[TB] FAIL wrap_en1: got %b, expected 1", imem_en); end
    if (imem_addr !== 9'h000) begin tests_failed++; $display("[TB] FAIL wrap_addr1: got %h, expected 000", imem_addr); end
    tick;
    fetch_en = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (imem_en !== 1'b0)     begin tests_failed++; $display("[TB] FAIL wrap_halt_en: got %b, expected 0", imem_en); end
    if (imem_addr !== 9'h001) begin tests_failed++; $display("[TB] FAIL wrap_addr2: got %h, expected 001", imem_addr); end
    wait_drain(20, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL wrap_drain: %0d entries left, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_redirect_ready();
    test_interrupt();
    test_halt_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised next-generation instruction fetch stage for the 5-stage CPU. It generates sequential PCs and drives a synchronous 1-cycle-latency instruction ROM. Returned words go into a DEPTH-entry prefetch queue, which feeds decode over a valid/ready handshake. It also supports branch redirect with flush, fetch enable/halt, and prioritised multi-line interrupt injection with a busy lock until the handler signals completion.

Parameters:
N, 32, instruction/PC width
DEPTH, 4, prefetch queue entries; power of 2, minimum 2
ADDR_W, 9, ROM word-address width
RESET_PC, 32'h0, PC value loaded at reset
NUM_IRQ, 2, number of interrupt request lines
IRQ_INST, 32'hA7C00000, instruction word injected on interrupt

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
fetch_en  in  1  permit new ROM requests; low = halt issue, queue still drains
redirect_valid  in  1  branch/jump redirect
redirect_pc  in  N  redirect target
imem_en  out  1  ROM read strobe
imem_addr  out  ADDR_W  ROM word address = PC[ADDR_W+1:2]
imem_rdata  in  N  ROM data, valid exactly 1 cycle after imem_en
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts
inst  out  N  instruction word
inst_pc  out  N  PC of inst
inst_irq  out  NUM_IRQ  one-hot interrupt source when inst is injected, else 0
irq  in  NUM_IRQ  level interrupt requests
irq_done  in  1  handler-complete pulse; clears busy lock
irq_busy  out  1  interrupt injected and not yet completed

Behaviour:
- Reset (async): PC=RESET_PC, queue count=0, inflight=0, irq_busy=0. All outputs 0, except imem_addr=RESET_PC[ADDR_W+1:2].
- pop = inst_valid & inst_ready & ~inst_irq-injection. issue = fetch_en & ~redirect_valid & (count + inflight - pop < DEPTH).
- On issue: imem_en=1, imem_addr from PC, inflight<=1 with captured pc_q<=PC, PC<=PC+4 (wraps mod 2^N).
- Response: in the cycle after issue, {imem_rdata, pc_q} is pushed at the next edge unless it is squashed. Push and pop in the same cycle leave count unchanged.
- Latency: first imem_en is asserted at the first edge after rst_n rises with fetch_en=1. inst_valid rises 2 edges later. Throughput is 1 instr/cycle with inst_ready held high.
- Queue is FIFO with wrap-around pointers. inst/inst_pc show the head entry. inst_valid = (count!=0 | irq-injection) & ~redirect_valid.
- Full: issue suppressed by the credit rule. No overflow is possible. A push when full is an assertion failure.
- Redirect (priority over all): inst_valid is forced low that cycle, so no transfer occurs. At the edge: queue flushed (count=0), inflight response squashed, PC<=redirect_pc. Issue resumes the next cycle, subject to fetch_en.
- fetch_en low: PC holds, no new issue. A response already inflight is still pushed.
- Interrupt injection:
  - Condition: |irq & ~irq_busy & ~redirect_valid.
  - Outputs: inst=IRQ_INST, inst_valid=1, inst_irq=one-hot of the highest set index.
  - inst_pc = queue head PC if count!=0, else pc_q if inflight, else PC. This is the return address.
  - The queue is not popped. On handshake, irq_busy<=1. Queue contents remain; downstream redirects to the handler.
- irq_busy clears on irq_done. If irq_done and a new injection handshake occur in the same cycle, set wins.
- Reset mid-operation: immediate return to reset state. Any inflight ROM data is ignored.

Test Plan:
- Reset/sequential: RESET_PC=0, fetch_en=1, inst_ready=1 → imem_addr 0,1,2,...; inst_pc 0x0,0x4,0x8 on consecutive cycles; inst_valid first high 2 edges after reset release.
- Backpressure/full: DEPTH=4, inst_ready=0 → exactly 4 issues, then imem_en=0. Raise inst_ready → 4 entries drain in order, then issue restarts with no gap or duplicate.
- Redirect with full queue and inflight: redirect_pc=0x100 → inst_valid=0 that cycle, no stale word delivered, next inst_pc=0x100, then 0x104.
- Redirect simultaneous with inst_ready=1 and a valid head → head not consumed (no transfer), flushed, delivery restarts at target.
- Interrupt: irq=2'b11 while head pc=0x20 → inst=0xA7C00000, inst_irq=2'b10, inst_pc=0x20, irq_busy=1. irq stays high → no second injection until the irq_done pulse, after which re-injection occurs.
- Halt and wrap: fetch_en=0 mid-stream → PC holds and the queue drains to empty. redirect_pc=0xFFFFFFFC → next PC wraps to 0x0.
